// File: rtl/mpc_mul_share_arbiter.sv
// Round-robin scheduler sharing one pipelined signed multiplier among N
// requesters. Grants one operand pair per enabled cycle, tracks the owner of
// each in-flight product through a tag pipeline matched to the multiplier
// latency, and returns each product tagged with its requester ID.
module mpc_mul_share_arbiter #(
    parameter int N   = 4,
    parameter int AW  = 21,
    parameter int BW  = 8,
    parameter int PW  = AW + BW,
    parameter int LAT = 3,
    parameter int IDW = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [N-1:0]                 req_valid,
    input  logic [N*AW-1:0]              req_a,
    input  logic [N*BW-1:0]              req_b,
    output logic [N-1:0]                 req_ready,
    output logic signed [AW-1:0]         mul_a,
    output logic signed [BW-1:0]         mul_b,
    output logic                         mul_ce,
    input  logic signed [PW-1:0]         mul_p,
    output logic                         rsp_valid,
    output logic [IDW-1:0]               rsp_id,
    output logic signed [PW-1:0]         rsp_p,
    output logic [$clog2(LAT+1)-1:0]     in_flight
);

    localparam int CW = $clog2(LAT + 1);

    // Unpacked views of the packed operand buses
    logic signed [AW-1:0] a_arr [N];
    logic signed [BW-1:0] b_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*AW +: AW];
        assign b_arr[i] = req_b[i*BW +: BW];
    end

    // Control state: round-robin pointer, valid pipe, tag pipe, occupancy
    logic [IDW-1:0] rr_ptr;
    logic [LAT-1:0] vld_p;
    logic [IDW-1:0] tag_p [LAT];
    logic [LAT-1:0] vld_nxt;

    // Arbitration results
    logic           grant_any;
    logic [IDW-1:0] gidx;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW:0]   scan_sum;
    logic [IDW-1:0] scan_idx;

    function automatic logic [CW-1:0] popcnt(input logic [LAT-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < LAT; k++) begin
            if (v[k]) c = c + 1'b1;
        end
        return c;
    endfunction

    // Round-robin search from rr_ptr upward, wrapping modulo N; reset and ce gate the grant
    always_comb begin
        grant_any = 1'b0;
        gidx      = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int off = 0; off < N; off++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW+1)'(off);
            if (scan_sum >= (IDW+1)'(N)) scan_sum = scan_sum - (IDW+1)'(N);
            scan_idx = scan_sum[IDW-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                gidx      = scan_idx;
            end
        end
        if (!(ce && rst)) begin
            grant_any = 1'b0;
        end
        ptr_nxt = (gidx == IDW'(N - 1)) ? '0 : gidx + 1'b1;
    end

    // Grant and multiplier operand drive; bubbles present zero operands
    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grant_any) begin
            req_ready[gidx] = 1'b1;
            mul_a           = a_arr[gidx];
            mul_b           = b_arr[gidx];
        end
    end

    // Next-state of the valid pipe: new issue enters at stage 0
    always_comb begin
        vld_nxt    = '0;
        vld_nxt[0] = grant_any;
        for (int k = 1; k < LAT; k++) begin
            vld_nxt[k] = vld_p[k-1];
        end
    end

    // Pointer, valid/tag pipelines and occupancy advance only on enabled edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            vld_p     <= '0;
            in_flight <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_p[k] <= '0;
            end
        end else if (ce) begin
            if (grant_any) begin
                rr_ptr <= ptr_nxt;
            end
            vld_p     <= vld_nxt;
            in_flight <= popcnt(vld_nxt);
            tag_p[0]  <= gidx;
            for (int k = 1; k < LAT; k++) begin
                tag_p[k] <= tag_p[k-1];
            end
        end
    end

    assign mul_ce    = ce;
    assign rsp_valid = ce & vld_p[LAT-1];
    assign rsp_id    = tag_p[LAT-1];
    assign rsp_p     = mul_p;

endmodule

// File: tb/tb_mpc_mul_share_arbiter.sv
// Bench for mpc_mul_share_arbiter: behavioural 3-stage multiplier, reference
// round-robin model, and a scoreboard queue of expected tagged products.
module tb_mpc_mul_share_arbiter;

    localparam int N   = 4;
    localparam int AW  = 21;
    localparam int BW  = 8;
    localparam int PW  = AW + BW;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     ce  = 1'b1;
    logic [N-1:0]             req_valid = '0;
    logic [N*AW-1:0]          req_a = '0;
    logic [N*BW-1:0]          req_b = '0;
    logic [N-1:0]             req_ready;
    logic signed [AW-1:0]     mul_a;
    logic signed [BW-1:0]     mul_b;
    logic                     mul_ce;
    logic signed [PW-1:0]     mul_p;
    logic                     rsp_valid;
    logic [IDW-1:0]           rsp_id;
    logic signed [PW-1:0]     rsp_p;
    logic [1:0]               in_flight;

    mpc_mul_share_arbiter #(
        .N(N), .AW(AW), .BW(BW), .PW(PW), .LAT(LAT), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: LAT register stages, frozen by ce, never reset
    logic signed [PW-1:0] ea, eb, m1, m2, m3;
    assign ea    = mul_a;
    assign eb    = mul_b;
    assign mul_p = m3;
    always @(posedge clk) begin
        if (mul_ce) begin
            m1 <= ea * eb;
            m2 <= m1;
            m3 <= m2;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    // Requester state driven by the stimulus process
    int           a_v [N];
    int           b_v [N];
    int           pend [N];
    logic [N-1:0] vld_r = '0;

    // Reference model state owned by the monitor
    typedef struct { int id; longint p; int due; } sb_t;
    sb_t          sb [$];
    int           mptr = 0;
    int           ce_edges = 0;
    logic [N-1:0] gnt_seen = '0;

    // Count enabled, non-reset edges
    always @(posedge clk) begin
        if (rst && ce) ce_edges++;
    end

    // Monitor: compare outputs against the model half a cycle after each edge
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_in_flight", in_flight, 0);
            mptr = 0;
            sb.delete();
            gnt_seen = '0;
        end else begin
            int  g;
            int  idx;
            bit  exp_rv;
            sb_t e;
            check_eq("in_flight", in_flight, sb.size());
            check_eq("mul_ce", mul_ce, ce);
            exp_rv = (sb.size() > 0) && ce && (sb[0].due == ce_edges);
            check_eq("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                check_eq("rsp_id", rsp_id, sb[0].id);
                check_eq("rsp_p", rsp_p, sb[0].p);
                void'(sb.pop_front());
            end
            g = -1;
            for (int off = 0; off < N; off++) begin
                idx = (mptr + off) % N;
                if (g < 0 && ce && req_valid[idx]) g = idx;
            end
            check_eq("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
            if (g >= 0) begin
                check_eq("mul_a", mul_a, a_v[g]);
                check_eq("mul_b", mul_b, b_v[g]);
                e.id  = g;
                e.p   = longint'(a_v[g]) * longint'(b_v[g]);
                e.due = ce_edges + LAT;
                sb.push_back(e);
                mptr = (g + 1) % N;
            end
            gnt_seen = req_ready & req_valid;
        end
    end

    function automatic int rand_a();
        return int'($urandom_range(0, 2097151)) - 1048576;
    endfunction

    function automatic int rand_b();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(a_v[i]);
            req_b[i*BW +: BW] = BW'(b_v[i]);
        end
        req_valid = vld_r;
    endtask

    task automatic load(input int i, input int a, input int b, input int cnt);
        a_v[i]   = a;
        b_v[i]   = b;
        pend[i]  = cnt;
        vld_r[i] = 1'b1;
        drive_bus();
    endtask

    // Advance one cycle; granted requesters present their next op or drop valid
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_seen[i]) begin
                pend[i]--;
                if (pend[i] > 0) begin
                    a_v[i] = rand_a();
                    b_v[i] = rand_b();
                end else begin
                    vld_r[i] = 1'b0;
                end
            end
        end
        drive_bus();
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            done = (vld_r == '0) && (sb.size() == 0);
        end
        check_eq("idle_timeout", done, 1);
        tick();
    endtask

    task automatic wait_grant(input int i);
        bit done;
        done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            tick();
            done = (pend[i] == 0);
        end
        check_eq("grant_timeout", done, 1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            a_v[i]  = 0;
            b_v[i]  = 0;
            pend[i] = 0;
        end

        // Reset held with every requester valid
        for (int i = 0; i < N; i++) load(i, 100 * (i + 1), -(i + 1), 1);
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("first_grant_after_reset", req_ready, 1);
        wait_idle();

        // Full load: all requesters valid continuously
        for (int i = 0; i < N; i++) load(i, rand_a(), rand_b(), 6);
        wait_idle();

        // Single op
        load(0, 1000, -3, 1);
        wait_idle();

        // Stall with another requester waiting; extreme operands
        load(1, -1048576, -128, 1);
        wait_grant(1);
        ce = 1'b0;
        load(0, 77, -5, 1);
        tick();
        tick();
        ce = 1'b1;
        wait_idle();

        // Pointer now 1: req0 and req2 valid -> grant 2, then 0
        load(0, 12345, 7, 1);
        load(2, -54321, 99, 1);
        @(negedge clk);
        check_eq("wrap_grant_2", req_ready, 4);
        tick();
        @(negedge clk);
        check_eq("wrap_grant_0", req_ready, 1);
        wait_idle();

        // Reset mid-flight: two ops issued then dropped
        load(2, 500, 3, 1);
        load(3, -600, 4, 1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("midflight_in_flight", in_flight, 0);
        check_eq("midflight_rsp_valid", rsp_valid, 0);
        tick();
        rst = 1'b1;
        repeat (6) tick();

        // Random traffic with ce toggling and occasional withdrawals
        for (int c = 0; c < 400; c++) begin
            tick();
            ce = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!vld_r[i] && $urandom_range(0, 2) == 0) begin
                    load(i, rand_a(), rand_b(), int'($urandom_range(1, 3)));
                end else if (vld_r[i] && $urandom_range(0, 15) == 0) begin
                    pend[i]  = 0;
                    vld_r[i] = 1'b0;
                    drive_bus();
                end
            end
        end
        ce = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpc_mul_share_arbiter.md
Name: mpc_mul_share_arbiter

Overview:
- Round-robin arbiter and scheduler sharing one pipelined 21s x 8s -> 29s multiplier instance among N requesters in the MPC datapath.
- Grants at most one operand pair per clock-enabled cycle and drives the multiplier's a, b and ce.
- Carries each operation's requester ID through a tag pipeline matched to the multiplier latency, and returns the product tagged to the right requester.

Parameters:
- N, 4, number of requesters (2..8).
- AW, 21, operand A width, signed.
- BW, 8, operand B width, signed.
- PW, 29, product width, signed; fixed as AW+BW.
- LAT, 3, multiplier latency in ce-enabled clock edges from operand capture to valid p.
- IDW, 2, requester ID width; equals clog2(N).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ce  in  1  global clock enable; low freezes the whole block and the multiplier.
- req_valid  in  N  per-requester operand valid.
- req_a  in  N*AW  packed signed A operands; requester i at bits [i*AW +: AW].
- req_b  in  N*BW  packed signed B operands; requester i at bits [i*BW +: BW].
- req_ready  out  N  one-hot grant; operand accepted this cycle.
- mul_a  out  AW  to multiplier a.
- mul_b  out  BW  to multiplier b.
- mul_ce  out  1  to multiplier ce.
- mul_p  in  PW  from multiplier p.
- rsp_valid  out  1  product valid this cycle.
- rsp_id  out  IDW  requester that owns rsp_p.
- rsp_p  out  PW  signed product.
- in_flight  out  clog2(LAT+1)  number of valid operations in the pipeline.

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0; valid pipe vld[0..LAT-1]=0; tag pipe=0.
  - Outputs held: req_ready=0, rsp_valid=0, in_flight=0.
  - Multiplier registers are not reset; stale mul_p is ignored because vld is 0.
- Arbitration (combinational, ce=1 only):
  - Search req_valid starting at index rr_ptr, increasing, wrapping modulo N.
  - The first set index g is granted: req_ready[g]=1, mul_a=req_a[g], mul_b=req_b[g].
  - No valid requester: req_ready=0, mul_a=0, mul_b=0, and a bubble is issued.
  - ce=0: req_ready=0 regardless of req_valid.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] & req_ready[i].
  - A requester keeps req_valid and its operands stable until granted.
  - A requester may drop req_valid before grant without penalty.
- Pointer update: on a transfer edge, rr_ptr <= (g+1) mod N. It is unchanged on bubbles and when ce=0.
- Multiplier drive: mul_ce=ce, combinational pass-through.
- Pipeline, on each edge with ce=1:
  - vld[0] <= grant_any; tag[0] <= g.
  - vld[k] <= vld[k-1] and tag[k] <= tag[k-1] for k=1..LAT-1.
  - With ce=0, vld and tag hold.
- Response:
  - rsp_valid = ce & vld[LAT-1]; rsp_id = tag[LAT-1]; rsp_p = mul_p.
  - A product issued on edge t is presented after the LAT-th ce-enabled edge counted from t, so it is consumed exactly once.
  - rsp_valid is masked while ce=0, so stall cycles never duplicate a response.
- in_flight: popcount of vld[0..LAT-1], registered form; updates only with ce.
- Throughput: one issue per ce-enabled cycle. Back-to-back grants to the same requester are legal when it is the only one valid.
- Reset mid-operation: all in-flight operations are dropped, rsp_valid is never asserted for them, and no requester is re-granted automatically.
- Arithmetic: full-precision signed product; no rounding or saturation. Range is -2^27 .. 2^27, which fits PW=29.

Test Plan:
- Reset: hold rst=0 with all req_valid=1 and ce=1 -> req_ready=0, rsp_valid=0, in_flight=0. Release rst -> requester 0 is granted first.
- Single op: req0 a=1000, b=-3, ce=1 -> req_ready[0]=1 for one cycle; 3 edges later rsp_valid=1, rsp_id=0, rsp_p=-3000. No further responses.
- Full load: all 4 requesters valid continuously, ce=1 -> grant order 0,1,2,3,0,1 on successive cycles. Responses appear in the same ID order, 3 cycles delayed, one per cycle, with in_flight=3 in steady state.
- Stall: req1 a=-1048576, b=-128 granted, then ce=0 for 2 cycles -> no grants and rsp_valid=0 during the stall. rsp_p=134217728 with rsp_id=1 is presented after the 3rd ce-enabled edge.
- Pointer wrap/skip: rr_ptr=1 with req0 and req2 valid -> grant 2 (rr_ptr becomes 3), next cycle grant 0 (rr_ptr becomes 1).
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle -> no rsp_valid for either op; in_flight=0 immediately on reset.
